// File: rtl/vme_cycle_seq.sv
// VME slave cycle sequencer: dispatches a start pulse to the selected handler, waits for its ack,
// drives DTACK/BERR until strobe release. Optional ack timeout under macro VME_SEQ_TIMEOUT_EN.
module vme_cycle_seq #(
  parameter logic [9:0] DEV_MASK   = 10'h3FF,
  parameter int         TMO_W      = 8,
  parameter int         TMO_CYCLES = 255,
  parameter int         REL_CYC    = 2
) (
  input  logic        i_fastclk,
  input  logic        i_rst,
  input  logic        i_strobe,
  input  logic        i_strbce,
  input  logic [9:0]  i_device,
  input  logic        i_write_b,
  input  logic [9:0]  i_dev_ack,
  output logic [9:0]  o_dev_strb,
  output logic        o_dev_wr,
  output logic [3:0]  o_dev_idx,
  output logic        o_dtack_b,
  output logic        o_berr_b,
  output logic        o_busy,
  output logic [15:0] o_cyc_cnt,
  output logic [7:0]  o_err_cnt
);

  typedef enum logic [2:0] {IDLE, DISPATCH, WAIT_ACK, ACK, ERR, RELEASE} state_t;

  localparam logic [3:0] REL_LD = 4'(REL_CYC);

  state_t      r_state, w_nxt_state;
  logic [9:0]  r_dev_strb, w_nxt_strb;
  logic        r_dev_wr, w_nxt_wr;
  logic [3:0]  r_dev_idx, w_nxt_idx;
  logic        r_dtack_b, w_nxt_dtack_b;
  logic        r_berr_b, w_nxt_berr_b;
  logic        r_busy;
  logic [15:0] r_cyc_cnt;
  logic [7:0]  r_err_cnt;
  logic [3:0]  r_rel;
  logic        w_cyc_inc, w_err_inc, w_rel_ld;
  logic [3:0]  w_nbits, w_idx;
  logic        w_valid, w_ack;
  logic [9:0]  w_sel;

`ifdef VME_SEQ_TIMEOUT_EN
  logic [TMO_W-1:0] r_tmo;
`else
  logic w_unused_tmo;
  assign w_unused_tmo = ^{TMO_W[0], TMO_CYCLES[0]};
`endif

  // Exactly one select bit, and that device enabled.
  always_comb begin
    w_nbits = '0;
    w_idx   = '0;
    for (int i = 0; i < 10; i++) begin
      if (i_device[i]) begin
        w_nbits = w_nbits + 4'd1;
        w_idx   = 4'(i);
      end
    end
  end

  assign w_valid = (w_nbits == 4'd1) && |(i_device & DEV_MASK);
  assign w_sel   = 10'd1 << r_dev_idx;
  assign w_ack   = |(i_dev_ack & w_sel);

  always_comb begin
    w_nxt_state   = r_state;
    w_nxt_strb    = '0;
    w_nxt_wr      = r_dev_wr;
    w_nxt_idx     = r_dev_idx;
    w_nxt_dtack_b = r_dtack_b;
    w_nxt_berr_b  = r_berr_b;
    w_cyc_inc     = 1'b0;
    w_err_inc     = 1'b0;
    w_rel_ld      = 1'b0;
    case (r_state)
      IDLE: begin
        if (i_strbce && i_strobe) begin
          if (w_valid) begin
            w_nxt_state = DISPATCH;
            w_nxt_idx   = w_idx;
            w_nxt_wr    = ~i_write_b;
            w_nxt_strb  = i_device;
          end else begin
            w_nxt_state  = ERR;
            w_nxt_berr_b = 1'b0;
          end
        end
      end
      DISPATCH: w_nxt_state = WAIT_ACK;
      WAIT_ACK: begin
        if (!i_strobe) begin
          w_nxt_state = IDLE;
        end else if (w_ack) begin
          w_nxt_state   = ACK;
          w_nxt_dtack_b = 1'b0;
        end
`ifdef VME_SEQ_TIMEOUT_EN
        else if (r_tmo == TMO_W'(1)) begin
          w_nxt_state  = ERR;
          w_nxt_berr_b = 1'b0;
        end
`endif
      end
      ACK: begin
        if (!i_strobe) begin
          w_nxt_state   = RELEASE;
          w_nxt_dtack_b = 1'b1;
          w_cyc_inc     = 1'b1;
          w_rel_ld      = 1'b1;
        end
      end
      ERR: begin
        if (!i_strobe) begin
          w_nxt_state  = RELEASE;
          w_nxt_berr_b = 1'b1;
          w_err_inc    = 1'b1;
          w_rel_ld     = 1'b1;
        end
      end
      RELEASE: begin
        if (r_rel <= 4'd1) w_nxt_state = IDLE;
      end
      default: w_nxt_state = IDLE;
    endcase
  end

  always_ff @(posedge i_fastclk) begin
    if (i_rst) begin
      r_state    <= IDLE;
      r_dev_strb <= '0;
      r_dev_wr   <= 1'b0;
      r_dev_idx  <= '0;
      r_dtack_b  <= 1'b1;
      r_berr_b   <= 1'b1;
      r_busy     <= 1'b0;
      r_cyc_cnt  <= '0;
      r_err_cnt  <= '0;
      r_rel      <= '0;
    end else begin
      r_state    <= w_nxt_state;
      r_dev_strb <= w_nxt_strb;
      r_dev_wr   <= w_nxt_wr;
      r_dev_idx  <= w_nxt_idx;
      r_dtack_b  <= w_nxt_dtack_b;
      r_berr_b   <= w_nxt_berr_b;
      r_busy     <= (w_nxt_state != IDLE);
      if (w_cyc_inc && (r_cyc_cnt != '1)) r_cyc_cnt <= r_cyc_cnt + 16'd1;
      if (w_err_inc && (r_err_cnt != '1)) r_err_cnt <= r_err_cnt + 8'd1;
      if (w_rel_ld) r_rel <= REL_LD;
      else if (r_state == RELEASE) r_rel <= r_rel - 4'd1;
    end
  end

`ifdef VME_SEQ_TIMEOUT_EN
  // Reloaded on every dispatch, so an aborted cycle's leftover count is harmless.
  always_ff @(posedge i_fastclk) begin
    if (i_rst) r_tmo <= '0;
    else if (r_state == DISPATCH) r_tmo <= TMO_W'(TMO_CYCLES);
    else if (r_state == WAIT_ACK) r_tmo <= r_tmo - TMO_W'(1);
  end
`endif

  assign o_dev_strb = r_dev_strb;
  assign o_dev_wr   = r_dev_wr;
  assign o_dev_idx  = r_dev_idx;
  assign o_dtack_b  = r_dtack_b;
  assign o_berr_b   = r_berr_b;
  assign o_busy     = r_busy;
  assign o_cyc_cnt  = r_cyc_cnt;
  assign o_err_cnt  = r_err_cnt;

endmodule

// File: tb/tb_vme_cycle_seq.sv
// Scoreboard bench for vme_cycle_seq: per-cycle expected outputs are queued at drive time and
// compared one edge later. Timeout scenarios run only when VME_SEQ_TIMEOUT_EN is defined.
module tb_vme_cycle_seq;
  localparam logic [9:0] MASK = 10'h3BF;  // device 6 disabled
  localparam int TMO = 4;
  localparam int REL = 2;
`ifdef VME_SEQ_TIMEOUT_EN
  localparam int ACKC = 4;
`else
  localparam int ACKC = 6;
`endif

  typedef struct packed {
    logic [9:0]  strb;
    logic        wr;
    logic [3:0]  idx;
    logic        dtack_b;
    logic        berr_b;
    logic        busy;
    logic [15:0] cyc;
    logic [7:0]  err;
  } outs_t;

  logic clk = 1'b0, rst = 1'b1, strobe = 1'b0, strbce = 1'b0, write_b = 1'b1;
  logic [9:0]  device = '0, dev_ack = '0;
  logic [9:0]  dev_strb;
  logic        dev_wr, dtack_b, berr_b, busy;
  logic [3:0]  dev_idx;
  logic [15:0] cyc_cnt;
  logic [7:0]  err_cnt;
  outs_t obs;
  outs_t sb[$];
  int nchk = 0, nerr = 0;
  logic [15:0] e_cyc = '0;
  logic [7:0]  e_err = '0;
  logic [3:0]  e_idx = '0;
  logic        e_wr  = 1'b0;

  vme_cycle_seq #(.DEV_MASK(MASK), .TMO_W(8), .TMO_CYCLES(TMO), .REL_CYC(REL)) dut (
    .i_fastclk(clk), .i_rst(rst), .i_strobe(strobe), .i_strbce(strbce), .i_device(device),
    .i_write_b(write_b), .i_dev_ack(dev_ack), .o_dev_strb(dev_strb), .o_dev_wr(dev_wr),
    .o_dev_idx(dev_idx), .o_dtack_b(dtack_b), .o_berr_b(berr_b), .o_busy(busy),
    .o_cyc_cnt(cyc_cnt), .o_err_cnt(err_cnt));

  always #5 clk = ~clk;
  assign obs = {dev_strb, dev_wr, dev_idx, dtack_b, berr_b, busy, cyc_cnt, err_cnt};

  task automatic drive(input logic s, input logic sc, input logic [9:0] d, input logic wb,
                       input logic [9:0] a);
    strobe = s; strbce = sc; device = d; write_b = wb; dev_ack = a;
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    outs_t e;
    rst = 1'b1;
    drive(1'b1, 1'b1, 10'h001, 1'b0, '0);
    for (int k = 0; k < 2; k++) begin
      e = '{strb: '0, wr: 1'b0, idx: '0, dtack_b: 1'b1, berr_b: 1'b1, busy: 1'b0, cyc: '0, err: '0};
      sb.push_back(e);
      step();
      e = sb.pop_front();
      nchk++;
      if (obs !== e) begin nerr++; $display("FAIL reset k%0d got %h exp %h", k, obs, e); end
    end
    rst = 1'b0;
    drive(1'b0, 1'b0, '0, 1'b1, '0);
    step();
  endtask

  task automatic test_valid_write();
    outs_t e;
    int drop = 10;
    for (int k = 0; k <= 13; k++) begin
      drive(k < drop, k == 0, 10'h008, 1'b0,
            (k == ACKC) ? 10'h008 : ((k == 2) ? 10'h100 : 10'h000));
      if (k == 0) begin e_idx = 4'd3; e_wr = 1'b1; end
      if (k == drop) e_cyc++;
      e = '{strb: (k == 0) ? 10'h008 : 10'h000, wr: e_wr, idx: e_idx,
            dtack_b: !((k + 1 >= ACKC + 1) && (k + 1 <= drop)), berr_b: 1'b1,
            busy: (k + 1 <= drop + REL), cyc: e_cyc, err: e_err};
      sb.push_back(e);
      step();
      e = sb.pop_front();
      nchk++;
      if (obs !== e) begin nerr++; $display("FAIL valid_write cyc%0d got %h exp %h", k + 1, obs, e); end
    end
  endtask

  task automatic test_invalid();
    logic [9:0] devs[3];
    outs_t e;
    int drop = 3;
    devs[0] = 10'h000; devs[1] = 10'h003; devs[2] = 10'h040;
    for (int c = 0; c < 3; c++) begin
      for (int k = 0; k <= 6; k++) begin
        drive(k < drop, k == 0, devs[c], 1'b1, devs[c]);
        if (k == drop) e_err++;
        e = '{strb: '0, wr: e_wr, idx: e_idx, dtack_b: 1'b1,
              berr_b: !((k + 1 >= 1) && (k + 1 <= drop)),
              busy: (k + 1 <= drop + REL), cyc: e_cyc, err: e_err};
        sb.push_back(e);
        step();
        e = sb.pop_front();
        nchk++;
        if (obs !== e) begin nerr++; $display("FAIL invalid%0d cyc%0d got %h exp %h", c, k + 1, obs, e); end
      end
    end
    nchk++;
    if (err_cnt !== 8'd3) begin nerr++; $display("FAIL invalid_errcnt got %0d exp 3", err_cnt); end
  endtask

`ifdef VME_SEQ_TIMEOUT_EN
  task automatic test_timeout();
    outs_t e;
    int drop = 9;
    for (int k = 0; k <= 12; k++) begin
      drive(k < drop, k == 0, 10'h020, 1'b0, 10'h001);
      if (k == 0) begin e_idx = 4'd5; e_wr = 1'b1; end
      if (k == drop) e_err++;
      e = '{strb: (k == 0) ? 10'h020 : 10'h000, wr: e_wr, idx: e_idx, dtack_b: 1'b1,
            berr_b: !((k + 1 >= 6) && (k + 1 <= drop)),
            busy: (k + 1 <= drop + REL), cyc: e_cyc, err: e_err};
      sb.push_back(e);
      step();
      e = sb.pop_front();
      nchk++;
      if (obs !== e) begin nerr++; $display("FAIL timeout cyc%0d got %h exp %h", k + 1, obs, e); end
    end
  endtask

  task automatic test_tie();
    outs_t e;
    int drop = 8;
    for (int k = 0; k <= 11; k++) begin
      drive(k < drop, k == 0, 10'h004, 1'b1, (k == 5) ? 10'h004 : 10'h000);
      if (k == 0) begin e_idx = 4'd2; e_wr = 1'b0; end
      if (k == drop) e_cyc++;
      e = '{strb: (k == 0) ? 10'h004 : 10'h000, wr: e_wr, idx: e_idx,
            dtack_b: !((k + 1 >= 6) && (k + 1 <= drop)), berr_b: 1'b1,
            busy: (k + 1 <= drop + REL), cyc: e_cyc, err: e_err};
      sb.push_back(e);
      step();
      e = sb.pop_front();
      nchk++;
      if (obs !== e) begin nerr++; $display("FAIL tie cyc%0d got %h exp %h", k + 1, obs, e); end
    end
  endtask
`else
  task automatic test_stall();
    outs_t e;
    int drop = 1001;
    for (int k = 0; k <= drop + 1; k++) begin
      drive(k < drop, k == 0, 10'h001, 1'b0, 10'h002);
      if (k == 0) begin e_idx = 4'd0; e_wr = 1'b1; end
      e = '{strb: (k == 0) ? 10'h001 : 10'h000, wr: e_wr, idx: e_idx, dtack_b: 1'b1,
            berr_b: 1'b1, busy: (k + 1 <= drop), cyc: e_cyc, err: e_err};
      sb.push_back(e);
      step();
      e = sb.pop_front();
      nchk++;
      if (obs !== e) begin nerr++; $display("FAIL stall cyc%0d got %h exp %h", k + 1, obs, e); end
    end
  endtask
`endif

  task automatic test_abort();
    outs_t e;
    int drop = 3;
    for (int k = 0; k <= 5; k++) begin
      drive(k < drop, k == 0, 10'h010, 1'b1, 10'h000);
      if (k == 0) begin e_idx = 4'd4; e_wr = 1'b0; end
      e = '{strb: (k == 0) ? 10'h010 : 10'h000, wr: e_wr, idx: e_idx, dtack_b: 1'b1,
            berr_b: 1'b1, busy: (k + 1 <= drop), cyc: e_cyc, err: e_err};
      sb.push_back(e);
      step();
      e = sb.pop_front();
      nchk++;
      if (obs !== e) begin nerr++; $display("FAIL abort cyc%0d got %h exp %h", k + 1, obs, e); end
    end
  endtask

  task automatic test_reset_in_ack();
    outs_t e;
    for (int k = 0; k <= 6; k++) begin
      rst = (k == 4);
      drive(k < 5, (k == 0) || (k == 5), 10'h002, 1'b0, (k == 2) ? 10'h002 : 10'h000);
      if (k == 0) begin e_idx = 4'd1; e_wr = 1'b1; end
      if (k == 4) begin e_idx = '0; e_wr = 1'b0; e_cyc = '0; e_err = '0; end
      e = '{strb: (k == 0) ? 10'h002 : 10'h000, wr: e_wr, idx: e_idx,
            dtack_b: !((k + 1 >= 3) && (k + 1 <= 4)), berr_b: 1'b1,
            busy: (k + 1 <= 4), cyc: e_cyc, err: e_err};
      sb.push_back(e);
      step();
      e = sb.pop_front();
      nchk++;
      if (obs !== e) begin nerr++; $display("FAIL reset_in_ack cyc%0d got %h exp %h", k + 1, obs, e); end
    end
    rst = 1'b0;
  endtask

  initial begin
    test_reset();
    test_valid_write();
    test_invalid();
`ifdef VME_SEQ_TIMEOUT_EN
    test_timeout();
    test_tie();
`else
    test_stall();
`endif
    test_abort();
    test_reset_in_ack();
    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end
endmodule
